// File: rtl/gpu_cmd_queue.sv
// Command FIFO in front of gpu_core: replays {command, data} pairs over stb/ack, captures read data.
// Optional ack watchdog is enabled by defining GPU_CMDQ_TIMEOUT_EN.
module gpu_cmd_queue #(
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_valid,
  output logic                         push_ready,
  input  logic [31:0]                  push_command,
  input  logic [63:0]                  push_data,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [31:0]                  gpu_command,
  output logic [63:0]                  gpu_data_in,
  output logic                         gpu_stb,
  input  logic                         gpu_ack,
  input  logic [63:0]                  gpu_data_out,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [63:0]                  rsp_data,
  output logic                         err_timeout,
  output logic [1:0]                   dbg_state
);

  // Handshakes: a push transfers when push_valid & push_ready at posedge; a response is
  // consumed when rsp_valid & rsp_ready at posedge; gpu_stb is held with stable payload until gpu_ack.

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [31:0]        r_cmd_mem  [DEPTH];
  logic [63:0]        r_data_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [LVL_W-1:0]   r_level;
  logic [31:0]        r_gpu_cmd;
  logic [63:0]        r_gpu_data;
  logic               r_rsp_valid;
  logic [63:0]        r_rsp_data;

  logic               w_push;
  logic               w_pop;
  logic               w_load;
  logic               w_capture;
  logic               w_timeout;
  logic [31:0]        w_head_cmd;
  logic               w_head_read;
  logic               w_issuable;

  assign push_ready  = (r_level != LVL_W'(DEPTH));
  assign w_push      = push_valid & push_ready;
  assign w_head_cmd  = r_cmd_mem[r_rd_ptr];
  assign w_head_read = (w_head_cmd[15:12] == 4'b0000);
  // A read may only issue if the response register will be free to take its result.
  assign w_issuable  = (r_level != '0) && !(w_head_read && r_rsp_valid && !rsp_ready);

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_issuable) begin
          w_state_nxt = S_ISSUE;
          w_load      = 1'b1;
        end
      end
      S_ISSUE: begin
        if (gpu_ack) begin
          w_pop       = 1'b1;
          w_capture   = w_head_read;
          w_state_nxt = S_GAP;
        end else if (w_timeout) begin
          w_pop       = 1'b1;
          w_state_nxt = S_GAP;
        end
      end
      S_GAP:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_cmd_mem[r_wr_ptr]  <= push_command;
      r_data_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gpu_cmd  <= '0;
      r_gpu_data <= '0;
    end else if (w_load) begin
      r_gpu_cmd  <= w_head_cmd;
      r_gpu_data <= r_data_mem[r_rd_ptr];
    end
  end

  // A capture wins over a same-cycle consume so the new result is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else if (w_capture) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= gpu_data_out;
    end else if (r_rsp_valid && rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

`ifdef GPU_CMDQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES+1);
  logic [CNT_W-1:0] r_to_cnt;
  logic             r_err;

  assign w_timeout = (r_state == S_ISSUE) && (r_to_cnt == CNT_W'(TIMEOUT_CYCLES-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_load)                    r_to_cnt <= '0;
      else if (r_state == S_ISSUE)   r_to_cnt <= r_to_cnt + 1'b1;
      if (w_timeout && !gpu_ack)     r_err    <= 1'b1;
    end
  end

  assign err_timeout = r_err;
`else
  assign w_timeout   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign level       = r_level;
  assign gpu_command = r_gpu_cmd;
  assign gpu_data_in = r_gpu_data;
  assign gpu_stb     = (r_state == S_ISSUE);
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign dbg_state   = r_state;

endmodule
